// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS core: operand forwarding, load-use and
// branch stalls, EX flush, and the multi-cycle mult/div occupancy sequencer.
module hazard_unit #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rsD,
    input  logic [4:0]           rtD,
    input  logic [4:0]           rsE,
    input  logic [4:0]           rtE,
    input  logic [4:0]           writeRegAddrE,
    input  logic [4:0]           writeRegAddrM,
    input  logic [4:0]           writeRegAddrW,
    input  logic                 regWriteE,
    input  logic                 regWriteM,
    input  logic                 regWriteW,
    input  logic                 memToRegE,
    input  logic                 memToRegM,
    input  logic                 branchD,
    input  logic                 jumpRegD,
    input  logic                 mdStartE,
    output logic [1:0]           forwardAE,
    output logic [1:0]           forwardBE,
    output logic                 forwardAD,
    output logic                 forwardBD,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 stallE,
    output logic                 flushE,
    output logic                 mdBusy,
    output logic [CNT_WIDTH-1:0] stallCount
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;

    localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 1);

    mdState_t   state;
    logic [3:0] cnt;

    logic lwStall;
    logic brStall;
    logic mdStall;
    logic anyStall;
    logic hitRsD;
    logic hitRtD;

    // EX operand select: the younger producer in M takes priority over W
    function automatic logic [1:0] fwdSel(input logic [4:0] src,
                                          input logic       wrM,
                                          input logic [4:0] addrM,
                                          input logic       wrW,
                                          input logic [4:0] addrW);
        if (wrM && addrM != 5'd0 && addrM == src)
            return 2'b01;
        else if (wrW && addrW != 5'd0 && addrW == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // A decode compare operand is not yet available if still in EX or being loaded in M
    function automatic logic decodeHit(input logic [4:0] src,
                                       input logic       wrE,
                                       input logic [4:0] addrE,
                                       input logic       ldM,
                                       input logic [4:0] addrM);
        return (src != 5'd0) && ((wrE && addrE == src) || (ldM && addrM == src));
    endfunction

    always_comb begin
        hitRsD   = decodeHit(rsD, regWriteE, writeRegAddrE, memToRegM, writeRegAddrM);
        hitRtD   = decodeHit(rtD, regWriteE, writeRegAddrE, memToRegM, writeRegAddrM);
        lwStall  = memToRegE && regWriteE && (writeRegAddrE != 5'd0) &&
                   ((writeRegAddrE == rsD) || (writeRegAddrE == rtD));
        brStall  = (branchD || jumpRegD) && (hitRsD || (branchD && hitRtD));
        mdStall  = ((state == IDLE) && mdStartE) || (state == BUSY);
        anyStall = (lwStall || brStall || mdStall) && !rst;
    end

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushE    = 1'b0;
        mdBusy    = 1'b0;
        if (!rst) begin
            forwardAE = fwdSel(rsE, regWriteM, writeRegAddrM, regWriteW, writeRegAddrW);
            forwardBE = fwdSel(rtE, regWriteM, writeRegAddrM, regWriteW, writeRegAddrW);
            forwardAD = regWriteM && (writeRegAddrM != 5'd0) && (writeRegAddrM == rsD);
            forwardBD = regWriteM && (writeRegAddrM != 5'd0) && (writeRegAddrM == rtD);
            stallF    = anyStall;
            stallD    = anyStall;
            stallE    = mdStall;
            flushE    = (lwStall || brStall) && !mdStall;
            mdBusy    = mdStall;
        end
    end

    // Mult/div occupancy: DONE releases EX for one cycle so the same op is not restarted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdStartE) begin
                        cnt   <= CNT_LOAD;
                        state <= (MD_LATENCY > 1) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stallCount <= '0;
        else if (anyStall)
            stallCount <= stallCount + CNT_WIDTH'(1);
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Generates the EX operand-forwarding selects (forwardAE/forwardBE) consumed by the execute stage.
- Also generates the decode-stage branch-compare forwarding, load-use and branch stalls, and EX flush.
- Sequences a multi-cycle mult/div occupancy stall and keeps a stall performance counter.

Parameters:
- MD_LATENCY, 4, total stall cycles for a mult/div op in EX (legal range 1..15).
- CNT_WIDTH, 32, width of stallCount.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- rsD, rtD  input  5 each  decode-stage source register addresses
- rsE, rtE  input  5 each  EX-stage source register addresses
- writeRegAddrE, writeRegAddrM, writeRegAddrW  input  5 each  destination register per stage
- regWriteE, regWriteM, regWriteW  input  1 each  destination write enable per stage
- memToRegE, memToRegM  input  1 each  instruction in that stage is a load
- branchD  input  1  conditional branch in decode (compares rs and rt)
- jumpRegD  input  1  jr/jalr in decode (uses rs only)
- mdStartE  input  1  mult/div instruction present in EX
- forwardAE, forwardBE  output  2 each  EX operand select: 00 register file, 01 aluOutM, 10 wbOut
- forwardAD, forwardBD  output  1 each  decode compare operand taken from aluOutM
- stallF, stallD, stallE  output  1 each  hold PC / IF-ID / ID-EX registers
- flushE  output  1  insert bubble into ID-EX
- mdBusy  output  1  mult/div sequencer occupying EX
- stallCount  output  CNT_WIDTH  number of cycles with stallD=1, wrapping

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE, counter to 0, stallCount to 0. While rst=1, all combinational outputs are forced low (forwardAE = forwardBE = 00). Reset mid-mult/div abandons the op immediately.
- forwardAE:
  - 01 if regWriteM && writeRegAddrM!=0 && writeRegAddrM==rsE;
  - else 10 if regWriteW && writeRegAddrW!=0 && writeRegAddrW==rsE;
  - else 00.
  - When both M and W match, M wins.
- forwardBE: same rule using rtE.
- forwardAD = regWriteM && writeRegAddrM!=0 && writeRegAddrM==rsD. forwardBD: same rule using rtD.
- lwstall = memToRegE && regWriteE && writeRegAddrE!=0 && (writeRegAddrE==rsD || writeRegAddrE==rtD).
- brstall = (branchD || jumpRegD) && (hit on rsD, or hit on rtD when branchD). A register counts as a hit if either:
  - regWriteE && writeRegAddrE==reg && reg!=0, or
  - memToRegM && writeRegAddrM==reg && reg!=0.
- mdStall = (state==IDLE && mdStartE) || state==BUSY.
- stallF = stallD = lwstall | brstall | mdStall.
- stallE = mdStall.
- flushE = (lwstall | brstall) & ~mdStall. EX is never flushed while it is held.
- mdBusy = mdStall.
- Mult/div FSM (4-bit down-counter cnt):
  - IDLE: if mdStartE, load cnt=MD_LATENCY-1. Go to BUSY if MD_LATENCY>1, else go to DONE.
  - BUSY: cnt decrements each cycle. When cnt==1, next state is DONE.
  - DONE: exactly one cycle with no md stall, so the op advances to M. mdStartE is ignored in DONE because the same instruction is still sampled. Next state is IDLE.
  - Total mdStall cycles per op = MD_LATENCY.
  - Back-to-back mult/div ops are separated by the DONE cycle.
- stallCount: increments on every clk edge where stallD=1; wraps from all-ones to 0.
- Simultaneous lwstall and mdStall: stalls assert; flushE=0. The load-use condition is re-evaluated after the md op releases.

Test Plan:
- regWriteM=1, writeRegAddrM=8, regWriteW=1, writeRegAddrW=8, rsE=8, rtE=9 -> forwardAE=01, forwardBE=00. Then writeRegAddrM=3 -> forwardAE=10. Then writeRegAddrM=writeRegAddrW=0, rsE=0 -> forwardAE=00.
- Load to $t0 in EX (memToRegE=1, regWriteE=1, writeRegAddrE=8), rtD=8 -> stallF=stallD=1, flushE=1, stallE=0 for one cycle; stallCount +1.
- branchD=1, rsD=5, regWriteE=1, writeRegAddrE=5 -> stall and flush. The next cycle, with the producer in M (non-load, regWriteM=1, writeRegAddrM=5) -> no stall, forwardAD=1.
- MD_LATENCY=4, mdStartE held high from cycle 0 -> mdBusy/stallE/stallF high in cycles 0-3 and low in cycle 4 (DONE). With mdStartE still high in cycle 5 -> a new 4-cycle stall begins. stallCount=8 after cycle 8.
- Assert rst in cycle 2 of a mult/div stall -> all outputs 0 immediately, FSM IDLE, stallCount=0. After rst drops, with mdStartE=0 -> no stall.
- lwstall condition during BUSY -> stallF=stallD=stallE=1, flushE=0 throughout.
